mem_access: RTL and testbench

- MEM-stage data-bus master. Consumes the EX/MEM pipeline-register outputs: ALU op, effective address, store data, destination register, write enable, result.
- Issues byte/half/word loads and stores to the data RAM over a req/ack bus, and stalls the pipeline while an access is outstanding.
- Presents the final write-back triple to MEM/WB. Load data is aligned and sign- or zero-extended. Misaligned accesses are flagged.

---
 rtl/mem_access.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage data-bus master: issues byte/half/word loads and stores over a req/ack bus,
// stalls the pipeline while an access is outstanding and produces the write-back triple.
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall_hold,
    input  logic [7:0]        mem_aluop,
    input  logic [ADDR_W-1:0] mem_mem_addr,
    input  logic [DATA_W-1:0] mem_reg2,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              stallreq,
    output logic              adel,
    output logic              ades
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t              r_state, w_state_next;
    logic                r_bus_req, r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [3:0]          r_bus_sel;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_size, r_off;
    logic                r_signed;
    logic [4:0]          r_wd;
    logic                r_wreg;

    logic                w_is_load, w_is_store, w_is_mem, w_signed, w_misaligned, w_issue;
    logic [1:0]          w_size;
    logic [3:0]          w_sel;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load_data;

    // Size encoding: 0 = byte, 1 = half, 2 = word.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        w_signed   = 1'b0;
        case (mem_aluop)
            OP_LB:  begin w_is_load = 1'b1; w_signed = 1'b1; end
            OP_LBU: begin w_is_load = 1'b1; end
            OP_LH:  begin w_is_load = 1'b1; w_signed = 1'b1; w_size = 2'd1; end
            OP_LHU: begin w_is_load = 1'b1; w_size = 2'd1; end
            OP_LW:  begin w_is_load = 1'b1; w_size = 2'd2; end
            OP_SB:  begin w_is_store = 1'b1; end
            OP_SH:  begin w_is_store = 1'b1; w_size = 2'd1; end
            OP_SW:  begin w_is_store = 1'b1; w_size = 2'd2; end
            default: ;
        endcase
    end

    assign w_is_mem     = w_is_load | w_is_store;
    assign w_misaligned = ((w_size == 2'd1) && mem_mem_addr[0]) ||
                          ((w_size == 2'd2) && (mem_mem_addr[1:0] != 2'b00));
    assign w_issue      = (r_state == IDLE) && w_is_mem && !w_misaligned && !flush;

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        case (w_size)
            2'd0: begin
                w_sel   = 4'b1000 >> mem_mem_addr[1:0];
                w_wdata = {4{mem_reg2[7:0]}};
            end
            2'd1: begin
                w_sel   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{mem_reg2[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = mem_reg2;
            end
        endcase
    end

    always_comb begin
        case (r_off)
            2'b00:   w_byte = r_rdata[31:24];
            2'b01:   w_byte = r_rdata[23:16];
            2'b10:   w_byte = r_rdata[15:8];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = r_off[1] ? r_rdata[15:0] : r_rdata[31:16];
        case (r_size)
            2'd0:    w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = r_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (w_issue) w_state_next = BUSY;
            BUSY: begin
                if (bus_ack)    w_state_next = flush ? IDLE : DONE;
                else if (flush) w_state_next = DRAIN;
            end
            DONE:  if (!stall_hold || flush) w_state_next = IDLE;
            DRAIN: if (bus_ack) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_size      <= 2'd0;
            r_off       <= 2'd0;
            r_signed    <= 1'b0;
            r_wd        <= 5'd0;
            r_wreg      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= w_is_store;
                r_bus_addr  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
                r_bus_sel   <= w_sel;
                r_bus_wdata <= w_wdata;
                r_size      <= w_size;
                r_off       <= mem_mem_addr[1:0];
                r_signed    <= w_signed;
                r_wd        <= mem_wd;
                r_wreg      <= mem_wreg & w_is_load;
            end else if (r_bus_req && bus_ack && (r_state == BUSY || r_state == DRAIN)) begin
                r_bus_req <= 1'b0;
                // Data arriving during DRAIN belongs to a flushed load and is dropped.
                if (r_state == BUSY) r_rdata <= bus_rdata;
            end
        end
    end

    always_comb begin
        wb_wd    = 5'd0;
        wb_wreg  = 1'b0;
        wb_wdata = '0;
        stallreq = 1'b0;
        adel     = 1'b0;
        ades     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_is_mem) begin
                    wb_wd    = mem_wd;
                    wb_wreg  = mem_wreg & !flush;
                    wb_wdata = mem_wdata;
                end else if (w_misaligned) begin
                    adel = w_is_load;
                    ades = w_is_store;
                end else begin
                    stallreq = !flush;
                end
            end
            BUSY, DRAIN: stallreq = 1'b1;
            DONE: begin
                wb_wd    = r_wd;
                wb_wreg  = r_wreg & !flush;
                wb_wdata = r_wreg ? w_load_data : '0;
            end
            default: ;
        endcase
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_sel   = r_bus_sel;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected write-back results are queued when an
// instruction is driven and compared when the DUT presents them.
module tb_mem_access;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_OR  = 8'b0010_0101;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst_n, flush, stall_hold, mem_wreg, bus_ack;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2, mem_wdata, bus_rdata;
    logic [4:0]  mem_wd;
    logic        bus_req, bus_we, wb_wreg, stallreq, adel, ades;
    logic [31:0] bus_addr, bus_wdata, wb_wdata;
    logic [3:0]  bus_sel;
    logic [4:0]  wb_wd;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } wb_t;

    wb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  req_edges = 0;
    logic req_prev = 1'b0;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_hold(stall_hold),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .adel(adel), .ades(ades)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_req && !req_prev) req_edges++;
        req_prev = bus_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    endtask

    task automatic drive_nop();
        drive(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    endtask

    // One aligned access: ack arrives after ack_delay request cycles, DONE held for hold cycles.
    task automatic access(input string name, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] wd, input logic [31:0] rdata,
                          input int ack_delay, input int hold, input logic [31:0] e_addr,
                          input logic [3:0] e_sel, input logic [31:0] e_wdata, input logic e_we,
                          input logic e_wreg, input logic [31:0] e_wb);
        int  k, stall_cnt, edges0;
        bit  done;
        wb_t e;
        next_cycle();
        edges0 = req_edges;
        drive(op, addr, reg2, wd, 1'b1, 32'h5555_AAAA);
        bus_rdata = rdata; bus_ack = 1'b0; stall_hold = 1'b0; flush = 1'b0;
        sb.push_back('{wd: wd, wreg: e_wreg, wdata: e_wb});
        #1;
        check({name, "_idle_stall"}, {31'd0, stallreq}, 32'd1);
        check({name, "_idle_req"}, {31'd0, bus_req}, 32'd0);
        stall_cnt = 1; done = 1'b0; k = 0;
        while (!done && k < 30) begin
            k++;
            next_cycle();
            if (k == 1) begin
                check({name, "_req"}, {31'd0, bus_req}, 32'd1);
                check({name, "_addr"}, bus_addr, e_addr);
                check({name, "_sel"}, {28'd0, bus_sel}, {28'd0, e_sel});
                check({name, "_we"}, {31'd0, bus_we}, {31'd0, e_we});
                if (e_we) check({name, "_wdata"}, bus_wdata, e_wdata);
            end
            bus_ack = ((k - 1) == ack_delay);
            #1;
            if (stallreq) stall_cnt++;
            else done = 1'b1;
        end
        bus_ack = 1'b0;
        check({name, "_done_seen"}, {31'd0, done}, 32'd1);
        check({name, "_stall_cycles"}, stall_cnt, ack_delay + 2);
        check({name, "_done_req"}, {31'd0, bus_req}, 32'd0);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({name, "_wb_wreg"}, {31'd0, wb_wreg}, {31'd0, e.wreg});
        if (e.wreg) begin
            check({name, "_wb_wd"}, {27'd0, wb_wd}, {27'd0, e.wd});
            check({name, "_wb_wdata"}, wb_wdata, e.wdata);
        end
        stall_hold = (hold > 0);
        for (int h = 1; h <= hold; h++) begin
            next_cycle();
            stall_hold = (h < hold);
            #1;
            check({name, "_hold_stall"}, {31'd0, stallreq}, 32'd0);
            check({name, "_hold_req"}, {31'd0, bus_req}, 32'd0);
            check({name, "_hold_wreg"}, {31'd0, wb_wreg}, {31'd0, e.wreg});
            if (e.wreg) check({name, "_hold_wdata"}, wb_wdata, e.wdata);
        end
        next_cycle();
        drive_nop();
        stall_hold = 1'b0;
        #1;
        check({name, "_after_stall"}, {31'd0, stallreq}, 32'd0);
        check({name, "_txn_count"}, req_edges - edges0, 32'd1);
        $display("txn %s op=%h addr=%h wb_wreg=%0b wb_wdata=%h", name, op, addr, e.wreg, e.wdata);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall_hold = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        drive_nop();
        repeat (2) next_cycle();
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_we", {31'd0, bus_we}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_sel", {28'd0, bus_sel}, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through of a non-memory op
        next_cycle();
        drive(OP_OR, 32'h100, 32'h0, 5'd5, 1'b1, 32'h1234);
        sb.push_back('{wd: 5'd5, wreg: 1'b1, wdata: 32'h1234});
        #1;
        begin
            wb_t e;
            e = sb.pop_front();
            check("pt_wd", {27'd0, wb_wd}, {27'd0, e.wd});
            check("pt_wreg", {31'd0, wb_wreg}, {31'd0, e.wreg});
            check("pt_wdata", wb_wdata, e.wdata);
            check("pt_stall", {31'd0, stallreq}, 32'd0);
        end
        repeat (2) begin
            next_cycle();
            check("pt_noreq", {31'd0, bus_req}, 32'd0);
        end
        $display("txn pass_through wd=5 wdata=1234");

        access("lb",  OP_LB,  32'h103, 32'h0, 5'd3, 32'h0000_00F0, 1, 0, 32'h100, 4'b0001, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0);
        access("lbu", OP_LBU, 32'h103, 32'h0, 5'd4, 32'h0000_00F0, 1, 0, 32'h100, 4'b0001, 32'h0, 1'b0, 1'b1, 32'h0000_00F0);
        access("lb1", OP_LB,  32'h101, 32'h0, 5'd6, 32'h1122_3344, 0, 0, 32'h100, 4'b0100, 32'h0, 1'b0, 1'b1, 32'h0000_0022);
        access("lh",  OP_LH,  32'h100, 32'h0, 5'd7, 32'h8001_7FFF, 0, 0, 32'h100, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001);
        access("lhu", OP_LHU, 32'h102, 32'h0, 5'd8, 32'h8001_9ABC, 2, 0, 32'h100, 4'b0011, 32'h0, 1'b0, 1'b1, 32'h0000_9ABC);
        access("sh",  OP_SH,  32'h202, 32'hABCD_1234, 5'd9, 32'h0, 1, 0, 32'h200, 4'b0011, 32'h1234_1234, 1'b1, 1'b0, 32'h0);
        access("sb",  OP_SB,  32'h201, 32'h1111_225A, 5'd10, 32'h0, 0, 0, 32'h200, 4'b0100, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0);
        access("sw",  OP_SW,  32'h204, 32'hDEAD_BEEF, 5'd11, 32'h0, 0, 0, 32'h204, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        access("lw_hold", OP_LW, 32'h300, 32'h0, 5'd12, 32'hCAFE_F00D, 2, 3, 32'h300, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);

        // Misaligned load and store
        next_cycle();
        drive(OP_LW, 32'h105, 32'h0, 5'd13, 1'b1, 32'h0);
        #1;
        check("mis_lw_adel", {31'd0, adel}, 32'd1);
        check("mis_lw_ades", {31'd0, ades}, 32'd0);
        check("mis_lw_wreg", {31'd0, wb_wreg}, 32'd0);
        check("mis_lw_stall", {31'd0, stallreq}, 32'd0);
        next_cycle();
        drive(OP_SW, 32'h106, 32'h0, 5'd0, 1'b0, 32'h0);
        check("mis_lw_noreq", {31'd0, bus_req}, 32'd0);
        #1;
        check("mis_sw_ades", {31'd0, ades}, 32'd1);
        check("mis_sw_adel", {31'd0, adel}, 32'd0);
        next_cycle();
        drive(OP_LH, 32'h101, 32'h0, 5'd14, 1'b1, 32'h0);
        check("mis_sw_noreq", {31'd0, bus_req}, 32'd0);
        #1;
        check("mis_lh_adel", {31'd0, adel}, 32'd1);
        next_cycle();
        drive_nop();
        check("mis_lh_noreq", {31'd0, bus_req}, 32'd0);
        $display("txn misaligned lw/sw/lh");

        // Flush while in IDLE suppresses the request
        next_cycle();
        drive(OP_LW, 32'h400, 32'h0, 5'd15, 1'b1, 32'h0);
        flush = 1'b1;
        #1;
        check("fidle_stall", {31'd0, stallreq}, 32'd0);
        check("fidle_wreg", {31'd0, wb_wreg}, 32'd0);
        next_cycle();
        flush = 1'b0; drive_nop();
        check("fidle_noreq", {31'd0, bus_req}, 32'd0);
        $display("txn flush_idle");

        // Flush in BUSY, ack two cycles later
        begin
            int edges0;
            logic saw_wreg;
            saw_wreg = 1'b0;
            next_cycle();
            edges0 = req_edges;
            drive(OP_LW, 32'h500, 32'h0, 5'd16, 1'b1, 32'h0);
            bus_rdata = 32'h7777_7777;
            next_cycle();
            check("fbusy_req1", {31'd0, bus_req}, 32'd1);
            flush = 1'b1;
            #1;
            saw_wreg |= wb_wreg;
            next_cycle();
            flush = 1'b0; drive_nop();
            #1;
            check("fbusy_req2", {31'd0, bus_req}, 32'd1);
            check("fbusy_stall2", {31'd0, stallreq}, 32'd1);
            saw_wreg |= wb_wreg;
            next_cycle();
            check("fbusy_req3", {31'd0, bus_req}, 32'd1);
            bus_ack = 1'b1;
            #1;
            saw_wreg |= wb_wreg;
            next_cycle();
            bus_ack = 1'b0;
            #1;
            check("fbusy_req_drop", {31'd0, bus_req}, 32'd0);
            check("fbusy_idle_stall", {31'd0, stallreq}, 32'd0);
            saw_wreg |= wb_wreg;
            next_cycle();
            check("fbusy_noreq", {31'd0, bus_req}, 32'd0);
            check("fbusy_never_wreg", {31'd0, saw_wreg}, 32'd0);
            check("fbusy_txn_count", req_edges - edges0, 32'd1);
            $display("txn flush_busy addr=500");
        end

        // Reset in the middle of an access
        next_cycle();
        drive(OP_LW, 32'h600, 32'h0, 5'd17, 1'b1, 32'h0);
        next_cycle();
        check("rbusy_req", {31'd0, bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rbusy_req_drop", {31'd0, bus_req}, 32'd0);
        drive_nop();
        #1;
        check("rbusy_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // ack with no outstanding request is ignored
        next_cycle();
        bus_ack = 1'b1;
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check("stray_ack_req", {31'd0, bus_req}, 32'd0);
        check("stray_ack_stall", {31'd0, stallreq}, 32'd0);
        $display("txn reset_mid_busy");

        access("lw_after", OP_LW, 32'h700, 32'h0, 5'd18, 32'h0BAD_F00D, 0, 0, 32'h700, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
